// File: rtl/if_stage_fetch_pkg.sv
// if_stage_fetch_pkg: shared types and constants for the instruction-fetch stage.
// Revision 1.0
`default_nettype none

package if_stage_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/if_stage_fetch_pc_next_calc.sv
// pc_next_calc: combinational next-PC adders for sequential fetch and decode redirects.
// Revision 1.0
`default_nettype none

module pc_next_calc
  import if_stage_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_pc_i,
  input  logic [XLEN-1:0] branch_offset_i,
  input  logic            branch_taken_i,
  output logic [XLEN-1:0] seq_pc_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic [XLEN-1:0] w_byte_offset;

  // Not-taken collapses redirect_pc to Instr_PC+4, the sequential successor.
  assign w_byte_offset = branch_taken_i ? (branch_offset_i << 2) : '0;
  assign seq_pc_o      = pc_i + 32'd4;
  assign redirect_pc_o = instr_pc_i + 32'd4 + w_byte_offset;

endmodule

`default_nettype wire

// File: rtl/if_stage_fetch.sv
// if_stage_fetch: PC holder, single outstanding memory fetch, valid/ready hand-off to decode.
// Revision 1.0
`default_nettype none

module if_stage_fetch
  import if_stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic        Mem_ack,
  input  logic [31:0] Mem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic        Instr_valid,
  input  logic        Instr_ready,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_offset,
  output logic [31:0] PC
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] redirect_pc;

  pc_next_calc u_pc_next_calc (
    .pc_i           (pc_q),
    .instr_pc_i     (instr_pc_q),
    .branch_offset_i(Branch_offset),
    .branch_taken_i (Branch_taken),
    .seq_pc_o       (seq_pc),
    .redirect_pc_o  (redirect_pc)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q       <= IDLE;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (Mem_ack) begin
          instr_d       = Mem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = seq_pc;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        // Branch_taken only matters here; elsewhere it never reaches a register.
        if (instr_valid_q && Instr_ready) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Mem_req     = (state_q == FETCH);
  assign Mem_addr    = {pc_q[31:2], 2'b00};
  assign Instr       = instr_q;
  assign Instr_PC    = instr_pc_q;
  assign Instr_valid = instr_valid_q;
  assign PC          = pc_q;

endmodule

`default_nettype wire
